// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst arbiter that tags producer beats with their index into a shared FIFO,
// plus a read stage that hides the FIFO's registered read latency behind a valid/ready output.
module fifo_rr_scheduler #(
  parameter  int NUM_REQ     = 4,
  parameter  int ID_WIDTH    = 2,
  parameter  int DATA_LEN    = 8,
  parameter  int BURST       = 4,
  parameter  int BURST_WIDTH = 3,
  localparam int FIFO_W      = ID_WIDTH + DATA_LEN
) (
  input  logic                         clk,
  input  logic                         sys_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_wr_en,
  output logic [FIFO_W-1:0]            fifo_data_in,
  output logic                         fifo_rd_en,
  input  logic [FIFO_W-1:0]            fifo_data_out,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [DATA_LEN-1:0]          out_data,
  output logic [ID_WIDTH-1:0]          grant_id,
  output logic                         busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    grant_q, grant_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   rd_pending_q;
  logic                   out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
  logic [DATA_LEN-1:0]    out_data_q, out_data_d;

  logic [2*NUM_REQ-1:0]   rot;
  logic                   pick_found;
  logic [ID_WIDTH-1:0]    pick_id;
  logic [ID_WIDTH:0]      pick_sum;
  logic                   sel_valid, sel_last;
  logic [DATA_LEN-1:0]    sel_data;
  logic [BURST_WIDTH-1:0] cnt_inc;

  // Rotate so bit 0 is the highest-priority requester; descending scan leaves the lowest hit.
  assign rot = {req_valid, req_valid} >> rr_ptr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
        if (pick_sum >= (ID_WIDTH+1)'(NUM_REQ))
          pick_sum = pick_sum - (ID_WIDTH+1)'(NUM_REQ);
        pick_id = pick_sum[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < NUM_REQ; i++)
          req_ready[i] = (grant_q == ID_WIDTH'(i)) && !fifo_full;
        // A full FIFO holds the grant without counting; a missing beat releases it.
        if (!sel_valid) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end else if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_data_in = {grant_q, sel_data};
          cnt_d        = cnt_inc;
          if (sel_last || cnt_inc == BURST_WIDTH'(BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = !fifo_empty && !rd_pending_q && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    if (rd_pending_q) begin
      out_valid_d = 1'b1;
      out_id_d    = fifo_data_out[FIFO_W-1 -: ID_WIDTH];
      out_data_d  = fifo_data_out[DATA_LEN-1:0];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= fifo_rd_en;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboarded bench for fifo_rr_scheduler with a depth-8 behavioural FIFO on its FIFO ports.
module tb_fifo_rr_scheduler;
  localparam int NR = 4, IW = 2, DL = 8, FW = IW + DL, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              sys_rst_n;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DL-1:0]  req_data;
  logic              fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_data_in, fifo_data_out;
  logic              out_valid, out_ready, busy;
  logic [IW-1:0]     out_id, grant_id;
  logic [DL-1:0]     out_data;

  fifo_rr_scheduler #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_LEN(DL), .BURST(4), .BURST_WIDTH(3)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
    .grant_id(grant_id), .busy(busy)
  );

  // Behavioural FIFO sharing the DUT reset; counts illegal write-when-full / read-when-empty.
  logic [FW-1:0] fmem [DEPTH];
  int fcnt = 0, fwp = 0, frp = 0, viol_wr = 0, viol_rd = 0;
  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fcnt <= 0; fwp <= 0; frp <= 0; fifo_data_out <= '0;
    end else begin
      if (fifo_wr_en && fcnt == DEPTH) viol_wr <= viol_wr + 1;
      if (fifo_rd_en && fcnt == 0)     viol_rd <= viol_rd + 1;
      if (fifo_wr_en && fcnt < DEPTH) begin
        fmem[fwp] <= fifo_data_in;
        fwp <= (fwp + 1) % DEPTH;
      end
      if (fifo_rd_en && fcnt > 0) begin
        fifo_data_out <= fmem[frp];
        frp <= (frp + 1) % DEPTH;
      end
      fcnt <= fcnt + ((fifo_wr_en && fcnt < DEPTH) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  int n_tests = 0, n_fail = 0;
  logic [FW-1:0] exp_q[$];

  logic [DL-1:0] pdat  [NR][16];
  logic          plast [NR][16];
  int            pn [NR], ph [NR];
  logic [NR-1:0] acc;

  int  glog[$], blog[$], llog[$], gaplog[$];
  int  cur_beats, cur_len, idle_run, wr_total;
  bit  prev_busy;

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    check({name, "_len"}, got.size(), want.size());
    foreach (want[k]) check(name, (k < got.size()) ? got[k] : -1, want[k]);
  endtask

  task automatic push(input int r, input logic [DL-1:0] d, input logic l);
    pdat[r][pn[r]]  = d;
    plast[r][pn[r]] = l;
    pn[r]++;
    exp_q.push_back({IW'(r), d});
  endtask

  // One cycle: retire beats accepted at the last edge, drive heads, then sample mid-cycle.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) ph[i]++;
      if (ph[i] < pn[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = plast[i][ph[i]];
        req_data[i*DL +: DL] = pdat[i][ph[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DL +: DL] = '0;
      end
    end
    #2;
    acc = req_valid & req_ready;
    if (fifo_wr_en) wr_total++;
    if (busy && !prev_busy) begin
      if (glog.size() > 0) gaplog.push_back(idle_run);
      glog.push_back(int'(grant_id));
      cur_beats = 0; cur_len = 0; idle_run = 0;
    end
    if (busy) begin
      cur_len++;
      if (fifo_wr_en) cur_beats++;
    end else begin
      idle_run++;
    end
    if (!busy && prev_busy) begin
      blog.push_back(cur_beats);
      llog.push_back(cur_len);
    end
    prev_busy = busy;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin pn[i] = 0; ph[i] = 0; end
    req_valid = '0; req_last = '0; req_data = '0; acc = '0;
    exp_q.delete(); glog.delete(); blog.delete(); llog.delete(); gaplog.delete();
    cur_beats = 0; cur_len = 0; idle_run = 0; wr_total = 0; prev_busy = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  // Output monitor: every accepted output beat must match the head of the scoreboard.
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (sys_rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", int'({out_id, out_data}), -1);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", int'({out_id, out_data}), int'(e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[$];
    int k;
    sys_rst_n = 1'b0; out_ready = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; acc = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", int'({out_id, out_data}), 0);
    do_reset();

    // Single burst from requester 1
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) push(1, 8'h10 + DL'(b), b == 3);
    step();
    check("t1_bubble_busy", busy, 0);
    step();
    check("t1_grant_id", grant_id, 1);
    check("t1_data_in", fifo_data_in, 'h110);
    for (int b = 0; b < 4; b++) begin
      if (b != 0) step();
      check("t1_wr_en", fifo_wr_en, 1);
      check("t1_busy", busy, 1);
    end
    step();
    check("t1_busy_drop", busy, 0);
    check("t1_wr_count", wr_total, 4);
    drain("t1_drain");

    // Round-robin over 0,2,3 with full bursts
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) push(0, 8'h00 + DL'(b), 1'b0);
    for (int b = 0; b < 4; b++) push(2, 8'h20 + DL'(b), 1'b0);
    for (int b = 0; b < 4; b++) push(3, 8'h30 + DL'(b), 1'b0);
    for (int b = 4; b < 8; b++) push(0, 8'h00 + DL'(b), 1'b0);
    drain("t2_drain");
    w = {0, 2, 3, 0}; check_seq("t2_grants", glog, w);
    w = {4, 4, 4, 4}; check_seq("t2_beats", blog, w);
    w = {1, 1, 1};    check_seq("t2_gaps", gaplog, w);

    // Early release of requester 2 after two beats
    do_reset();
    out_ready = 1'b1;
    push(0, 8'h01, 1'b1);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(3, 8'h31, 1'b1);
    push(0, 8'h02, 1'b1);
    drain("t3_drain");
    w = {0, 2, 3, 0}; check_seq("t3_grants", glog, w);
    w = {1, 2, 1, 1}; check_seq("t3_beats", blog, w);
    check("t3_grant2_cycles", (llog.size() > 1) ? llog[1] : -1, 3);

    // FIFO full: one beat parks in the output register, eight fill the FIFO
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 12; b++) push(0, 8'h40 + DL'(b), 1'b0);
    k = 0;
    while (fcnt != DEPTH && k < 60) begin step(); k++; end
    check("t4_full", fcnt, DEPTH);
    check("t4_writes_at_full", wr_total, 9);
    for (int c = 0; c < 6; c++) begin
      step();
      check("t4_ready_full", req_ready, 0);
      check("t4_wr_full", fifo_wr_en, 0);
      check("t4_busy_full", busy, 1);
    end
    check("t4_writes_held", wr_total, 9);
    out_ready = 1'b1;
    drain("t4_drain");
    check("t4_writes_total", wr_total, 12);
    w = {4, 4, 4}; check_seq("t4_beats", blog, w);

    // Output back-pressure
    do_reset();
    out_ready = 1'b0;
    push(1, 8'h50, 1'b0);
    push(1, 8'h51, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    check("t5_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("t5_hold_data", out_data, 'h50);
      check("t5_hold_id", out_id, 1);
      check("t5_no_rd", fifo_rd_en, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t5_rd_on_ready", fifo_rd_en, 1);
    drain("t5_drain");

    // Reset during GRANT with a read in flight
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) push(3, 8'h60 + DL'(b), 1'b0);
    k = 0;
    while (!fifo_rd_en && k < 20) begin step(); k++; end
    check("t6_rd_seen", fifo_rd_en, 1);
    check("t6_busy_pre", busy, 1);
    @(negedge clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_wr_en", fifo_wr_en, 0);
    check("t6_data_in", fifo_data_in, 0);
    check("t6_rd_en", fifo_rd_en, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_word", int'({out_id, out_data}), 0);
    do_reset();
    step();
    step();
    check("t6_no_stale", out_valid, 0);
    push(0, 8'h70, 1'b1);
    push(3, 8'h71, 1'b1);
    step();
    step();
    check("t6_first_prio", grant_id, 0);
    drain("t6_drain");

    check("fifo_wr_when_full", viol_wr, 0);
    check("fifo_rd_when_empty", viol_rd, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
